ssd_scan: RTL and testbench

Eight-digit multiplexed seven-segment display driver that consumes the 32-bit display word produced by the memory-mapped display register and shows it as eight hexadecimal digits. It sits directly downstream of that register, between the CPU's memory-mapped I/O and the board's common-anode display pins. It buffers new values and swaps them in only at frame boundaries, so a frame never shows digits from two different values.

---
 rtl/ssd_scan.sv | 153 +++++++++++++++
 tb/tb_ssd_scan.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan.sv
// Purpose : eight-digit multiplexed seven-segment driver showing a 32-bit word as hex.
// Latency : an/seg registered, lag digit index by 1 cycle; new value shown at next frame boundary (+1 cycle).
// Backpressure: none -- update is always accepted; last update within a frame wins.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   value      display word, nibble k shown on digit k (digit 0 rightmost)
//   update     one-cycle strobe qualifying value
//   an         digit enables, active-low, one-hot-low while scanning
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low, held off
//   frame_done one-cycle pulse after each 8-digit frame boundary
//
// Build option: define SSD_SCAN_LZB_EN for leading-zero blanking of digits 1..7.
module ssd_scan #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        update,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam logic [19:0] LP_LAST = 20'(CLK_DIV - 1);

  logic [19:0] r_prescaler;
  logic [2:0]  r_idx;
  logic [31:0] r_shadow;
  logic [31:0] r_disp;
  logic        r_pending;
  logic [7:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_frame_done;

  logic        w_tick;
  logic        w_boundary;
  logic [3:0]  w_nibble;
  logic [6:0]  w_seg;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_tick     = (r_prescaler == LP_LAST);
  // The tick that leaves digit 7 closes the frame.
  assign w_boundary = w_tick && (r_idx == 3'd7);
  assign w_nibble   = r_disp[{r_idx, 2'b00} +: 4];

`ifdef SSD_SCAN_LZB_EN
  // w_zero_from[k]: nibbles k..7 of disp are all zero.
  logic [7:0] w_zero_from;

  always_comb begin
    w_zero_from    = 8'h00;
    w_zero_from[7] = (r_disp[31:28] == 4'h0);
    for (int k = 6; k >= 0; k--) begin
      w_zero_from[k] = w_zero_from[k+1] && (r_disp[4*k +: 4] == 4'h0);
    end
  end

  always_comb begin
    w_seg = hex7(w_nibble);
    // Digit 0 is never blanked so a zero word still shows one "0".
    if ((r_idx != 3'd0) && w_zero_from[r_idx]) begin
      w_seg = 7'h7F;
    end
  end
`else
  always_comb begin
    w_seg = hex7(w_nibble);
  end
`endif

  // Scan timing: prescaler and digit index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prescaler <= 20'd0;
      r_idx       <= 3'd0;
    end else if (w_tick) begin
      r_prescaler <= 20'd0;
      r_idx       <= r_idx + 3'd1;
    end else begin
      r_prescaler <= r_prescaler + 20'd1;
    end
  end

  // Value buffering: shadow collects updates, disp swaps only at frame boundaries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow  <= 32'd0;
      r_disp    <= 32'd0;
      r_pending <= 1'b0;
    end else begin
      if (update) begin
        r_shadow <= value;
      end
      if (w_boundary) begin
        // An update landing on the boundary itself bypasses the shadow.
        if (update) begin
          r_disp <= value;
        end else if (r_pending) begin
          r_disp <= r_shadow;
        end
        r_pending <= 1'b0;
      end else if (update) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Registered outputs, driven from the pre-edge index so they trail it by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an         <= 8'hFF;
      r_seg        <= 7'h7F;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= ~(8'h01 << r_idx);
      r_seg        <= w_seg;
      r_frame_done <= w_boundary;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = 1'b1;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ssd_scan.sv
module tb_ssd_scan;

  localparam int C  = 4;
  localparam int FR = 8 * C;
  localparam logic [31:0] IDLE_VAL = 32'h0BADF00D;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        update = 1'b0;
  logic [31:0] value  = IDLE_VAL;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  always #5 clk = ~clk;

  ssd_scan #(.CLK_DIV(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .update     (update),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n       = 0;     // rising edges since reset release
  int a_seen  = 0;
  bit a_win   = 1'b0;

  int          ue[$];  // edge at which each update was sampled
  logic [31:0] uv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, n);
  endtask

  function automatic logic [6:0] hexseg(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  // Word on display before edge e: the last update sampled at or before
  // the most recent frame boundary (edges that are multiples of FR).
  function automatic logic [31:0] shown_word(input int e);
    int lim;
    logic [31:0] d;
    lim = ((e - 1) / FR) * FR;
    d   = 32'd0;
    foreach (ue[i]) if (ue[i] <= lim) d = uv[i];
    return d;
  endfunction

  int          m_idx;
  logic [31:0] m_word;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;

  always @(posedge clk) begin
    if (!reset) begin
      n = 0;
      ue.delete();
      uv.delete();
    end else begin
      n = n + 1;
      if (update) begin
        ue.push_back(n);
        uv.push_back(value);
      end
      #1;
      m_idx  = ((n - 1) / C) % 8;
      m_word = shown_word(n);
      m_an   = ~(8'h01 << m_idx);
      m_seg  = hexseg(4'((m_word >> (4 * m_idx)) & 32'hF));
`ifdef SSD_SCAN_LZB_EN
      if (m_idx > 0 && (m_word >> (4 * m_idx)) == 32'd0) m_seg = 7'h7F;
`endif
      chk("model_an", an, m_an);
      chk("model_seg", seg, m_seg);
      chk("model_dp", dp, 1'b1);
      chk("model_frame_done", frame_done, (n % FR) == 0);
      if (a_win && seg == 7'h08) a_seen++;
    end
  end

  task automatic wait_n(input int t);
    int guard = 0;
    while (n < t && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (n != t) begin
      n_total++;
      $display("FAIL wait_n: reached edge %0d expected %0d", n, t);
    end
  endtask

  task automatic upd(input int e, input logic [31:0] v);
    wait_n(e - 1);
    update = 1'b1;
    value  = v;
    @(negedge clk);
    update = 1'b0;
    value  = IDLE_VAL;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    reset = 1'b1;

    wait_n(1);
    chk("first_an", an, 8'hFE);
    chk("first_seg", seg, 7'h40);
    wait_n(5);
    chk("second_an", an, 8'hFD);
    wait_n(31);
    chk("fd_before", frame_done, 1'b0);
    wait_n(32);
    chk("fd_first", frame_done, 1'b1);
    chk("an_digit7", an, 8'h7F);
    wait_n(33);
    chk("fd_after", frame_done, 1'b0);

    // Mid-frame update: current frame stays 0, next frame shows it.
    upd(40, 32'h12345678);
    wait_n(50);
    chk("midframe_old", seg, 7'h40);
    wait_n(66);
    chk("upd_d0", seg, 7'h00);
    wait_n(94);
    chk("upd_d7", seg, 7'h79);

    // Two updates in one frame: only the last is ever shown.
    a_win = 1'b1;
    upd(100, 32'hAAAAAAAA);
    upd(110, 32'hFFFFFFFF);
    wait_n(130);
    chk("last_wins_d0", seg, 7'h0E);
    wait_n(158);
    chk("last_wins_d7", seg, 7'h0E);

    // Update on the boundary edge itself bypasses into the next frame.
    upd(192, 32'hDEADBEEF);
    wait_n(194);
    a_win = 1'b0;
    chk("no_A_shown", a_seen, 0);
    chk("bypass_d0", seg, 7'h0E);
    wait_n(198);
    chk("bypass_d1", seg, 7'h06);
    wait_n(222);
    chk("bypass_d7", seg, 7'h21);

    // Reset during digit 5 with an update pending.
    upd(230, 32'h11111111);
    wait_n(246);
    reset = 1'b0;
    #1;
    chk("async_an", an, 8'hFF);
    chk("async_seg", seg, 7'h7F);
    chk("async_fd", frame_done, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_n(1);
    chk("restart_an", an, 8'hFE);
    chk("restart_seg", seg, 7'h40);
    wait_n(66);
    chk("pending_lost", seg, 7'h40);

    upd(70, 32'h000000A5);
    wait_n(98);
    chk("a5_d0", seg, 7'h12);
    wait_n(102);
    chk("a5_d1", seg, 7'h08);
    wait_n(106);
    chk("a5_d2_an", an, 8'hFB);
`ifdef SSD_SCAN_LZB_EN
    chk("a5_d2", seg, 7'h7F);
`else
    chk("a5_d2", seg, 7'h40);
`endif
    wait_n(126);
`ifdef SSD_SCAN_LZB_EN
    chk("a5_d7", seg, 7'h7F);
`else
    chk("a5_d7", seg, 7'h40);
`endif
    upd(130, 32'h00000000);
    wait_n(162);
    chk("zero_d0", seg, 7'h40);
    wait_n(166);
`ifdef SSD_SCAN_LZB_EN
    chk("zero_d1", seg, 7'h7F);
`else
    chk("zero_d1", seg, 7'h40);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
